// File: rtl/ballot_capture.sv
// Ballot-unit front end: synchronises and debounces four candidate keys, rejects
// multi-key presses, and emits one registered vote strobe per officer arm.
module ballot_capture #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ballot_arm,
  input  logic [3:0] key,
  output logic       en,
  output logic [3:0] button,
  output logic       armed,
  output logic       invalid
);

  localparam int unsigned KEY_W  = 4;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DEBOUNCE,
    S_CAST,
    S_RELEASE
  } state_t;

  logic [KEY_W-1:0]  r_sync1;
  logic [KEY_W-1:0]  r_ks;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [KEY_W-1:0]  r_cand;
  logic              r_en;
  logic [CODE_W-1:0] r_button;
  logic              r_armed;
  logic              r_invalid;

  state_t            w_state_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [KEY_W-1:0]  w_cand_next;
  logic              w_en_next;
  logic [CODE_W-1:0] w_button_next;
  logic              w_armed_next;
  logic              w_invalid_next;
  logic [CODE_W-1:0] w_code;
  logic              w_ks_zero;
  logic              w_ks_multi;
  logic              w_ks_onehot;
  logic [CNT_W-1:0]  w_cnt_max;

  assign w_ks_zero   = (r_ks == '0);
  assign w_ks_multi  = ((r_ks & (r_ks - KEY_W'(1))) != '0);
  assign w_ks_onehot = !w_ks_zero && !w_ks_multi;
  assign w_cnt_max   = CNT_W'(DEB_CYCLES);

  // Counter-side candidate encoding of the captured one-hot key
  always_comb begin
    w_code = '0;
    case (r_cand)
      4'b0001: w_code = CODE_W'(1);
      4'b0010: w_code = CODE_W'(2);
      4'b0100: w_code = CODE_W'(3);
      4'b1000: w_code = CODE_W'(4);
      default: w_code = '0;
    endcase
  end

  // Synchroniser, state, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '0;
      r_ks      <= '0;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cand    <= '0;
      r_en      <= 1'b0;
      r_button  <= '0;
      r_armed   <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_sync1   <= key;
      r_ks      <= r_sync1;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_cand    <= w_cand_next;
      r_en      <= w_en_next;
      r_button  <= w_button_next;
      r_armed   <= w_armed_next;
      r_invalid <= w_invalid_next;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they align with it
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cand_next  = r_cand;

    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (ballot_arm && w_ks_zero) w_state_next = S_ARMED;
      end
      S_ARMED: begin
        w_cnt_next = '0;
        if (w_ks_onehot) begin
          w_state_next = S_DEBOUNCE;
          w_cand_next  = r_ks;
          w_cnt_next   = CNT_W'(1);
        end
      end
      S_DEBOUNCE: begin
        if (r_ks != r_cand) begin
          w_state_next = S_ARMED;
          w_cnt_next   = '0;
        end else if (r_cnt == w_cnt_max) begin
          w_state_next = S_CAST;
          w_cnt_next   = '0;
        end else if (r_cnt < w_cnt_max) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_CAST: begin
        w_state_next = S_RELEASE;
        w_cnt_next   = '0;
      end
      S_RELEASE: begin
        if (!w_ks_zero) begin
          w_cnt_next = '0;
        end else if (r_cnt == w_cnt_max) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt < w_cnt_max) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    w_en_next      = (w_state_next == S_CAST);
    w_button_next  = w_en_next ? w_code : '0;
    w_armed_next   = (w_state_next == S_ARMED) || (w_state_next == S_DEBOUNCE);
    w_invalid_next = (w_state_next == S_ARMED) && w_ks_multi;
  end

  assign en      = r_en;
  assign button  = r_button;
  assign armed   = r_armed;
  assign invalid = r_invalid;

endmodule

// File: tb/tb_ballot_capture.sv
// Self-checking bench for ballot_capture: per-scenario tasks plus a scoreboard
// of expected candidate codes consumed whenever the DUT strobes en.
module tb_ballot_capture;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ballot_arm;
  logic [3:0] key;
  logic       en;
  logic [3:0] button;
  logic       armed;
  logic       invalid;

  int         checks   = 0;
  int         errors   = 0;
  int         en_count = 0;
  logic [3:0] exp_q[$];
  logic       prev_en  = 1'b0;

  ballot_capture #(.DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .ballot_arm (ballot_arm),
    .key        (key),
    .en         (en),
    .button     (button),
    .armed      (armed),
    .invalid    (invalid)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every en pops one expected code; button idles at zero
  always @(negedge clk) begin
    logic [3:0] exp_code;
    if (rst !== 1'b0) begin
      prev_en = 1'b0;
    end else begin
      if (en === 1'b1) begin
        en_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_en: button=%b with no vote expected", button);
        end else begin
          exp_code = exp_q.pop_front();
          if (button !== exp_code) begin
            errors++;
            $display("FAIL vote_code: button=%b expected %b", button, exp_code);
          end
        end
        checks++;
        if (prev_en) begin
          errors++;
          $display("FAIL en_consecutive: en=1 on two cycles, expected single pulse");
        end
      end else begin
        checks++;
        if (button !== 4'b0000) begin
          errors++;
          $display("FAIL button_idle: button=%b expected 0000 while en=%b", button, en);
        end
      end
      prev_en = (en === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ballot_arm = 1'b0; key = 4'b0000;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic arm_pulse();
    ballot_arm = 1'b1;
    tick(1);
    ballot_arm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ballot_arm = 1'b0; key = 4'b0000;
    tick(2);
    checks++;
    if ({en, button, armed, invalid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b button=%b armed=%b invalid=%b expected all 0", en, button, armed, invalid);
    end
    rst = 1'b0;
    tick(2);
    checks++;
    if (armed !== 1'b0 || en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: armed=%b en=%b expected 0 0", armed, en);
    end
  endtask

  task automatic test_clean_vote();
    int start, lat;
    bit found;
    do_reset();
    arm_pulse();
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL clean_armed: armed=%b expected 1", armed);
    end
    start = en_count;
    exp_q.push_back(4'b0011);
    key = 4'b0100;
    found = 0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (en === 1'b1) begin found = 1; lat = i; break; end
    end
    checks++;
    if (!found || lat != DEB + 4) begin
      errors++;
      $display("FAIL clean_latency: found=%0d at negedge %0d expected %0d", found, lat, DEB + 4);
    end
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL clean_armed_at_cast: armed=%b expected 0", armed);
    end
    tick(12);
    checks++;
    if (en_count != start + 1) begin
      errors++;
      $display("FAIL clean_once: en pulses=%0d expected 1", en_count - start);
    end
    key = 4'b0000;
    tick(10);
    arm_pulse();
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL clean_back_to_idle: armed=%b expected 1 after re-arm", armed);
    end
  endtask

  task automatic test_no_arm();
    int start;
    do_reset();
    start = en_count;
    key = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      checks++;
      if (armed !== 1'b0) begin
        errors++;
        $display("FAIL no_arm_armed: cycle %0d armed=%b expected 0", i, armed);
      end
    end
    arm_pulse();
    tick(1);
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL arm_with_key_held: armed=%b expected 0", armed);
    end
    checks++;
    if (en_count != start) begin
      errors++;
      $display("FAIL no_arm_en: en pulses=%0d expected 0", en_count - start);
    end
    key = 4'b0000;
    tick(4);
  endtask

  task automatic test_bounce();
    int start;
    do_reset();
    arm_pulse();
    start = en_count;
    for (int i = 0; i < 6; i++) begin
      key = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(2);
    end
    checks++;
    if (en_count != start) begin
      errors++;
      $display("FAIL bounce_no_en: en pulses=%0d expected 0 during bounce", en_count - start);
    end
    exp_q.push_back(4'b0010);
    key = 4'b0010;
    tick(15);
    checks++;
    if (en_count != start + 1) begin
      errors++;
      $display("FAIL bounce_single: en pulses=%0d expected 1", en_count - start);
    end
    key = 4'b0000;
    tick(10);
  endtask

  task automatic test_multi_key();
    int start;
    do_reset();
    arm_pulse();
    start = en_count;
    key = 4'b0011;
    tick(10);
    checks++;
    if (invalid !== 1'b1) begin
      errors++;
      $display("FAIL multi_invalid: invalid=%b expected 1", invalid);
    end
    checks++;
    if (en_count != start) begin
      errors++;
      $display("FAIL multi_no_en: en pulses=%0d expected 0", en_count - start);
    end
    exp_q.push_back(4'b0001);
    key = 4'b0001;
    tick(4);
    checks++;
    if (invalid !== 1'b0) begin
      errors++;
      $display("FAIL multi_invalid_clear: invalid=%b expected 0", invalid);
    end
    tick(12);
    checks++;
    if (en_count != start + 1) begin
      errors++;
      $display("FAIL multi_vote: en pulses=%0d expected 1", en_count - start);
    end
    key = 4'b0000;
    tick(10);
  endtask

  task automatic test_single_vote();
    int start;
    do_reset();
    arm_pulse();
    start = en_count;
    exp_q.push_back(4'b0100);
    key = 4'b1000;
    tick(12);
    checks++;
    if (en_count != start + 1) begin
      errors++;
      $display("FAIL single_first: en pulses=%0d expected 1", en_count - start);
    end
    tick(5);
    key = 4'b0000;
    tick(1);
    arm_pulse();
    key = 4'b1000;
    tick(10);
    checks++;
    if (en_count != start + 1 || armed !== 1'b0) begin
      errors++;
      $display("FAIL single_no_revote: en pulses=%0d armed=%b expected 1 0", en_count - start, armed);
    end
    key = 4'b0000;
    tick(10);
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL single_stale_arm: armed=%b expected 0", armed);
    end
    arm_pulse();
    exp_q.push_back(4'b0100);
    key = 4'b1000;
    tick(12);
    checks++;
    if (en_count != start + 2) begin
      errors++;
      $display("FAIL single_rearm_vote: en pulses=%0d expected 2", en_count - start);
    end
    key = 4'b0000;
    tick(10);
  endtask

  task automatic test_reset_mid();
    int start;
    do_reset();
    arm_pulse();
    start = en_count;
    key = 4'b0100;
    repeat (6) @(negedge clk);
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL mid_armed: armed=%b expected 1 in debounce", armed);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({en, button, armed, invalid} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: en=%b button=%b armed=%b invalid=%b expected all 0", en, button, armed, invalid);
    end
    tick(2);
    key = 4'b0000;
    rst = 1'b0;
    tick(8);
    checks++;
    if (en_count != start || armed !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_vote: en pulses=%0d armed=%b expected 0 0", en_count - start, armed);
    end
    arm_pulse();
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL mid_idle: armed=%b expected 1 after arm", armed);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_clean_vote();
    test_no_arm();
    test_bounce();
    test_multi_key();
    test_single_vote();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d votes outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
